pingpong_counter_gen: RTL and testbench
=======================================

# pingpong_counter_gen

Second-generation ping-pong counter: a WIDTH-bit counter that steps between runtime bounds `min` and `max` on each `enable` tick. It adds three things over the fixed 4-bit, step-1 version:
- a programmable step,
- four operating modes,
- a pending-flip latch and synchronous load.

It sits behind the board-level debounce/one-pulse and clock-divider logic, and drives the BCD/seven-segment display path.

## Interface
- `WIDTH`, default 8: counter, bound, step and load width.
- `BCNT_W`, default 8: bounce-counter width (used only with `PPC_BOUNCE_CNT_EN`).

Ports:
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `rst_n`, in, 1: synchronous, active-high reset (the name is kept for the codebase; asserted = 1).
- `enable`, in, 1: count tick, one `clk` wide (from the divider).
- `flip`, in, 1: one-pulse direction-reversal request.
- `load`, in, 1: one-pulse synchronous load request.
- `load_val`, in, WIDTH: value to load.
- `max`, in, WIDTH: upper bound, inclusive.
- `min`, in, WIDTH: lower bound, inclusive.
- `step`, in, WIDTH: increment per tick; a value of 0 is treated as 1.
- `mode`, in, 2: 0 = ping-pong, 1 = wrap, 2 = one-shot, 3 = hold.
- `out`, out, WIDTH: counter value.
- `direction`, out, 1: 1 = up, 0 = down.
- `bound_pulse`, out, 1: one-cycle pulse on a bounce (mode 0) or a wrap (mode 1).
- `done`, out, 1: one-shot completion flag.
- `range_ok`, out, 1: combinational; 1 when max > min and min ≤ out ≤ max.
- `bounce_cnt`, out, BCNT_W: present only with `PPC_BOUNCE_CNT_EN`.

## Operation
**Priority per edge:** reset > load > tick.

**Reset:**
- `out` ← `min` (value sampled at that edge); `direction` ← 1.
- `flip_pend` ← 0; `bound_pulse` ← 0; `done` ← 0; `bounce_cnt` ← 0.

**Load:**
- Accepted only if min ≤ `load_val` ≤ max and max > min; otherwise ignored entirely.
- On accept: `out` ← `load_val`, `flip_pend` ← 0, `done` ← 0, `direction` unchanged.

**Flip latch:**
- `flip` sets `flip_pend`.
- Effective flip f = `flip` | `flip_pend`, consumed (pend ← 0) on a tick in modes 0–2.
- Retained in mode 3, while range is invalid, and across non-tick cycles.

**Tick** (`enable` = 1, no load, `range_ok` = 1):
- Effective direction d = `direction` ^ f.
- up_nxt = min(out + step, max), down_nxt = max(out − step, min), both computed in WIDTH+1 bits.
- Mode 0, ping-pong:
  - If d = 1 and out = max: d ← 0 (bounce).
  - If d = 0 and out = min: d ← 1 (bounce).
  - Then `out` ← d ? up_nxt : down_nxt; `direction` ← d.
  - `bound_pulse` ← 1 only on a bounce.
- Mode 1, wrap:
  - If d = 1 and out = max: `out` ← min, `bound_pulse` ← 1.
  - If d = 0 and out = min: `out` ← max, `bound_pulse` ← 1.
  - Otherwise step normally. `direction` ← d.
- Mode 2, one-shot:
  - Step toward the bound in d; `direction` ← d.
  - `done` ← 1 when the new out equals the bound in d.
  - While `done` = 1, `out` does not change.
  - A flip clears `done` and the step is taken in the new direction.
- Mode 3, hold: `out`, `direction` and `done` are unchanged.

**Invalid range** (`range_ok` = 0): ticks are ignored, state is held, and flips stay pending.

**Pulse clearing:** `bound_pulse` ← 0 on every edge that does not set it.

**Mode change:** takes effect on the next tick; no state is reset. `done` clears when `mode` ≠ 2.

## Timing
- All outputs except `range_ok` are registered.
- Latency is one cycle: `out` reflects a tick on the same edge that sampled `enable`.
- `bound_pulse` is high for exactly the cycle following the bouncing or wrapping edge.
- Simultaneous `flip` and `enable` apply the flip on that tick.
- A `flip` coincident with an accepted `load` is discarded.
- Bounds may change at any time; the next tick uses the sampled values.
- Reset mid-count reinitialises on the next edge regardless of the other inputs.

## Configuration
- `PPC_BOUNCE_CNT_EN` defined:
  - `bounce_cnt` increments, wrapping, on each edge that sets `bound_pulse`.
  - Cleared by reset and by an accepted load.
- Undefined: the port and its register are absent; all other behaviour is identical.

## Test plan
Common setup: WIDTH = 4, `enable` high every cycle unless stated.
- Ping-pong, min = 2, max = 5, step = 1, from reset → out 2,3,4,5,4,3,2,3. `direction` falls after 5; `bound_pulse` is high after the edges leaving 5 and leaving 2.
- Ping-pong, min = 0, max = 5, step = 2 → 0,2,4,5,3,1,0,2 (clamped at both ends). step = 0 → increments by 1.
- Wrap, min = 0, max = 3, step = 1 → 0,1,2,3,0,1. Then flip → direction 0, with out going 0→3 and `bound_pulse` high.
- Flip pulse with `enable` low, then enable 3 cycles later at out = 4, dir up, range 2..5 → out 3, direction 0, `flip_pend` cleared. A second tick continues down.
- One-shot, min = 1, max = 4, from reset → 1,2,3,4 then `done` = 1 and out holds at 4. Load 2 → out 2, `done` = 0.
- max = min = 3 → `range_ok` = 0 and ticks are ignored. load_val = 9 with range 2..5 is ignored. With `PPC_BOUNCE_CNT_EN`, 4 bounces give `bounce_cnt` = 4, then reset gives 0.

Source files
------------

// File: rtl/pingpong_counter_gen.sv
// Ping-pong/wrap/one-shot/hold counter with programmable step, pending flip and synchronous load.
// Optional bounce counter output enabled by defining PPC_BOUNCE_CNT_EN.
module pingpong_counter_gen #(
  parameter int WIDTH = 8
`ifdef PPC_BOUNCE_CNT_EN
  , parameter int BCNT_W = 8
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              flip,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [WIDTH-1:0]  max,
  input  logic [WIDTH-1:0]  min,
  input  logic [WIDTH-1:0]  step,
  input  logic [1:0]        mode,
  output logic [WIDTH-1:0]  out,
  output logic              direction,
  output logic              bound_pulse,
  output logic              done,
  output logic              range_ok
`ifdef PPC_BOUNCE_CNT_EN
  ,
  output logic [BCNT_W-1:0] bounce_cnt
`endif
);

  localparam logic [1:0] MODE_PING = 2'd0;
  localparam logic [1:0] MODE_WRAP = 2'd1;
  localparam logic [1:0] MODE_ONE  = 2'd2;
  localparam logic [1:0] MODE_HOLD = 2'd3;

  logic [WIDTH-1:0] r_out;
  logic             r_dir;
  logic             r_flip_pend;
  logic             r_pulse;
  logic             r_done;

  logic [WIDTH-1:0] w_step;
  logic [WIDTH:0]   w_up_sum;
  logic [WIDTH:0]   w_min_plus_step;
  logic [WIDTH-1:0] w_up_nxt;
  logic [WIDTH-1:0] w_down_nxt;
  logic [WIDTH-1:0] w_dir_nxt;
  logic [WIDTH-1:0] w_dir_bound;
  logic             w_range_ok;
  logic             w_load_ok;
  logic             w_tick;
  logic             w_f;
  logic             w_d;
  logic             w_at_max;
  logic             w_at_min;
  logic             w_bounce;

  assign w_step = (step == '0) ? WIDTH'(1) : step;

  // Saturating neighbours, evaluated one bit wider so overflow/underflow clamp cleanly.
  assign w_up_sum        = {1'b0, r_out} + {1'b0, w_step};
  assign w_up_nxt        = (w_up_sum > {1'b0, max}) ? max : w_up_sum[WIDTH-1:0];
  assign w_min_plus_step = {1'b0, min} + {1'b0, w_step};
  assign w_down_nxt      = ({1'b0, r_out} < w_min_plus_step) ? min : (r_out - w_step);

  assign w_range_ok = (max > min) && (r_out >= min) && (r_out <= max);
  assign w_load_ok  = load && (max > min) && (load_val >= min) && (load_val <= max);
  assign w_tick     = enable && w_range_ok && !w_load_ok;

  assign w_f         = flip | r_flip_pend;
  assign w_d         = r_dir ^ w_f;
  assign w_at_max    = (r_out == max);
  assign w_at_min    = (r_out == min);
  assign w_dir_nxt   = w_d ? w_up_nxt : w_down_nxt;
  assign w_dir_bound = w_d ? max : min;

  assign w_bounce = w_tick && ((mode == MODE_PING) || (mode == MODE_WRAP)) &&
                    ((w_d && w_at_max) || (!w_d && w_at_min));

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_out       <= min;
      r_dir       <= 1'b1;
      r_flip_pend <= 1'b0;
      r_pulse     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_pulse <= w_bounce;
      if (mode != MODE_ONE) r_done <= 1'b0;

      if (w_load_ok) begin
        r_out       <= load_val;
        r_flip_pend <= 1'b0;
        r_done      <= 1'b0;
      end else if (w_tick && (mode != MODE_HOLD)) begin
        r_flip_pend <= 1'b0;
        case (mode)
          MODE_PING: begin
            if (w_d && w_at_max) begin
              r_dir <= 1'b0;
              r_out <= w_down_nxt;
            end else if (!w_d && w_at_min) begin
              r_dir <= 1'b1;
              r_out <= w_up_nxt;
            end else begin
              r_dir <= w_d;
              r_out <= w_dir_nxt;
            end
          end
          MODE_WRAP: begin
            r_dir <= w_d;
            if (w_d && w_at_max)       r_out <= min;
            else if (!w_d && w_at_min) r_out <= max;
            else                       r_out <= w_dir_nxt;
          end
          default: begin
            // One-shot parks once done; only a flip restarts it.
            if (!r_done || w_f) begin
              r_dir  <= w_d;
              r_out  <= w_dir_nxt;
              r_done <= (w_dir_nxt == w_dir_bound);
            end
          end
        endcase
      end else begin
        r_flip_pend <= r_flip_pend | flip;
      end
    end
  end

`ifdef PPC_BOUNCE_CNT_EN
  logic [BCNT_W-1:0] r_bounce_cnt;

  always_ff @(posedge clk) begin
    if (rst_n || w_load_ok) r_bounce_cnt <= '0;
    else if (w_bounce)      r_bounce_cnt <= r_bounce_cnt + BCNT_W'(1);
  end

  assign bounce_cnt = r_bounce_cnt;
`endif

  assign out         = r_out;
  assign direction   = r_dir;
  assign bound_pulse = r_pulse;
  assign done        = r_done;
  assign range_ok    = w_range_ok;

endmodule

// File: tb/tb_pingpong_counter_gen.sv
// Directed bench for pingpong_counter_gen at WIDTH=4; checks bounce_cnt when PPC_BOUNCE_CNT_EN is defined.
module tb_pingpong_counter_gen;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic         flip = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] max_v = 4'd5;
  logic [W-1:0] min_v = 4'd2;
  logic [W-1:0] step_v = 4'd1;
  logic [1:0]   mode = 2'd0;
  logic [W-1:0] out;
  logic         direction;
  logic         bound_pulse;
  logic         done;
  logic         range_ok;
`ifdef PPC_BOUNCE_CNT_EN
  logic [7:0]   bounce_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  pingpong_counter_gen #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst), .enable(enable), .flip(flip), .load(load),
    .load_val(load_val), .max(max_v), .min(min_v), .step(step_v), .mode(mode),
    .out(out), .direction(direction), .bound_pulse(bound_pulse), .done(done),
    .range_ok(range_ok)
`ifdef PPC_BOUNCE_CNT_EN
    , .bounce_cnt(bounce_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    int p1_out[7] = '{3, 4, 5, 4, 3, 2, 3};
    int p1_dir[7] = '{1, 1, 1, 0, 0, 0, 1};
    int p1_pls[7] = '{0, 0, 0, 1, 0, 0, 1};
    int p2_out[7] = '{2, 4, 5, 3, 1, 0, 2};
    int w_out[4]  = '{1, 2, 3, 0};
    int w_pls[4]  = '{0, 0, 0, 1};
    int os_out[4] = '{2, 3, 4, 4};
    int os_done[4] = '{0, 0, 1, 1};

    // Reset state, ping-pong 2..5 step 1
    enable = 1'b1;
    do_reset();
    check("rst_out", out, 2);
    check("rst_dir", direction, 1);
    check("rst_pulse", bound_pulse, 0);
    check("rst_done", done, 0);
    check("rst_range_ok", range_ok, 1);
    for (int i = 0; i < 7; i++) begin
      cyc();
      check($sformatf("pp1_out[%0d]", i), out, p1_out[i]);
      check($sformatf("pp1_dir[%0d]", i), direction, p1_dir[i]);
      check($sformatf("pp1_pulse[%0d]", i), bound_pulse, p1_pls[i]);
    end

    // Ping-pong 0..5 step 2 with clamping, then step 0 acts as 1
    min_v = 4'd0; max_v = 4'd5; step_v = 4'd2;
    do_reset();
    check("pp2_rst_out", out, 0);
    for (int i = 0; i < 7; i++) begin
      cyc();
      check($sformatf("pp2_out[%0d]", i), out, p2_out[i]);
    end
    step_v = 4'd0;
    cyc();
    check("pp2_step0_out", out, 3);

    // Wrap 0..3, then flip at 0 wraps down to 3
    mode = 2'd1; min_v = 4'd0; max_v = 4'd3; step_v = 4'd1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc();
      check($sformatf("wrap_out[%0d]", i), out, w_out[i]);
      check($sformatf("wrap_pulse[%0d]", i), bound_pulse, w_pls[i]);
    end
    flip = 1'b1;
    cyc();
    flip = 1'b0;
    check("wrap_flip_out", out, 3);
    check("wrap_flip_dir", direction, 0);
    check("wrap_flip_pulse", bound_pulse, 1);

    // Pending flip across idle cycles
    mode = 2'd0; min_v = 4'd2; max_v = 4'd5;
    do_reset();
    cyc();
    cyc();
    check("pend_pre_out", out, 4);
    enable = 1'b0; flip = 1'b1;
    cyc();
    flip = 1'b0;
    cyc();
    cyc();
    check("pend_idle_out", out, 4);
    check("pend_idle_dir", direction, 1);
    enable = 1'b1;
    cyc();
    check("pend_tick_out", out, 3);
    check("pend_tick_dir", direction, 0);
    cyc();
    check("pend_tick2_out", out, 2);
    check("pend_tick2_dir", direction, 0);

    // One-shot 1..4, then load 2 clears done
    mode = 2'd2; min_v = 4'd1; max_v = 4'd4;
    do_reset();
    check("os_rst_out", out, 1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check($sformatf("os_out[%0d]", i), out, os_out[i]);
      check($sformatf("os_done[%0d]", i), done, os_done[i]);
    end
    load = 1'b1; load_val = 4'd2;
    cyc();
    load = 1'b0;
    check("os_load_out", out, 2);
    check("os_load_done", done, 0);
    check("os_load_dir", direction, 1);

    // Invalid range ignores ticks; out-of-range load is ignored
    mode = 2'd0; min_v = 4'd3; max_v = 4'd3;
    do_reset();
    check("inv_range_ok", range_ok, 0);
    cyc();
    check("inv_tick_out", out, 3);
    min_v = 4'd2; max_v = 4'd5; enable = 1'b0;
    #1;
    check("valid_range_ok", range_ok, 1);
    load = 1'b1; load_val = 4'd9;
    cyc();
    load = 1'b0;
    check("bad_load_out", out, 3);

`ifdef PPC_BOUNCE_CNT_EN
    // Range 2..3: every tick after the first bounces
    min_v = 4'd2; max_v = 4'd3; enable = 1'b1;
    do_reset();
    check("bcnt_rst", bounce_cnt, 0);
    for (int i = 0; i < 5; i++) cyc();
    check("bcnt_four", bounce_cnt, 4);
    do_reset();
    check("bcnt_clear", bounce_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
